// File: rtl/simon128_dec.sv
// Iterative Simon 128/128 decryption core: a forward key expansion reaches k66/k67,
// then 68 inverse rounds regenerate the round keys backwards, so no key RAM is needed.
module simon128_dec #(
  parameter int ROUNDS = 68,
  parameter int WORD   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [2*WORD-1:0]   ct_i,
  input  logic [2*WORD-1:0]   k0_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*WORD-1:0]   pt_o
);

  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [6:0] KEYEXP_LAST = 7'(ROUNDS - 3);
  localparam logic [6:0] LAST_ROUND  = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, KEYEXP, DECRYPT, DONE} state_t;

  state_t state, state_next;

  logic [WORD-1:0] x, y, ka, kb;
  logic [6:0]      cnt;
  logic [6:0]      z_idx_dec;
  logic            accept;

  function automatic logic [WORD-1:0] f_fn(input logic [WORD-1:0] v);
    return ({v[WORD-2:0], v[WORD-1]} & {v[WORD-9:0], v[WORD-1:WORD-8]})
         ^ {v[WORD-3:0], v[WORD-1:WORD-2]};
  endfunction

  function automatic logic [WORD-1:0] t_fn(input logic [WORD-1:0] v);
    return {v[2:0], v[WORD-1:3]} ^ {v[3:0], v[WORD-1:4]};
  endfunction

  // z[0] is the leftmost character of the constant, so bit i lives at Z2[61-i]
  function automatic logic zbit(input logic [6:0] idx);
    logic [6:0] m;
    logic [5:0] sel;
    m   = (idx >= 7'd62) ? idx - 7'd62 : idx;
    sel = 6'(7'd61 - m);
    return Z2[sel];
  endfunction

  assign accept    = (state == IDLE) && start_i;
  assign z_idx_dec = (cnt >= 7'd2) ? cnt - 7'd2 : 7'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = KEYEXP;
      KEYEXP:  if (cnt == KEYEXP_LAST) state_next = DECRYPT;
      DECRYPT: if (cnt == 7'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: in DECRYPT kb holds k_r and ka holds k_{r-1} at the start of round r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      ka     <= '0;
      kb     <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      pt_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x      <= ct_i[2*WORD-1:WORD];
            y      <= ct_i[WORD-1:0];
            ka     <= k0_i[WORD-1:0];
            kb     <= k0_i[2*WORD-1:WORD];
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        KEYEXP: begin
          ka <= kb;
          kb <= ~ka ^ t_fn(kb) ^ {{(WORD-1){1'b0}}, zbit(cnt)} ^ 64'h3;
          if (cnt == KEYEXP_LAST) cnt <= LAST_ROUND;
          else                    cnt <= cnt + 7'd1;
        end
        DECRYPT: begin
          x  <= y;
          y  <= x ^ f_fn(y) ^ kb;
          kb <= ka;
          ka <= ~kb ^ t_fn(ka) ^ {{(WORD-1){1'b0}}, zbit(z_idx_dec)} ^ 64'h3;
          if (cnt != 7'd0) cnt <= cnt - 7'd1;
        end
        DONE: begin
          pt_o   <= {x, y};
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon128_dec.sv
// Scoreboard bench for simon128_dec: expected plaintexts are queued on start and
// compared when done_o pulses; a reference Simon model supplies non-constant vectors.
module tb_simon128_dec;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [127:0] ct_i;
  logic [127:0] k0_i;
  logic         busy_o;
  logic         done_o;
  logic [127:0] pt_o;

  int compared;
  int mismatched;
  logic [127:0] sbQueue[$];
  logic [127:0] lastPt;

  localparam logic [61:0] Z2REF = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [127:0] STD_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] STD_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
  localparam logic [127:0] STD_PT  = 128'h63736564207372656c6c657661727420;

  simon128_dec dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .ct_i   (ct_i),
    .k0_i   (k0_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .pt_o   (pt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] refF(input logic [63:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic void refSchedule(input logic [127:0] key, output logic [63:0] k[68]);
    logic [63:0] zc;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      zc = {63'd0, Z2REF[61 - (i % 62)]};
      k[i+2] = ~k[i] ^ ror(k[i+1], 3) ^ ror(k[i+1], 4) ^ zc ^ 64'h3;
    end
  endfunction

  function automatic logic [127:0] refEncrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [63:0] k[68];
    logic [63:0] a, b, tmp;
    refSchedule(key, k);
    a = pt[127:64];
    b = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      tmp = a;
      a = b ^ refF(a) ^ k[i];
      b = tmp;
    end
    return {a, b};
  endfunction

  function automatic logic [127:0] refDecrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [63:0] k[68];
    logic [63:0] a, b, tmp;
    refSchedule(key, k);
    a = ct[127:64];
    b = ct[63:0];
    for (int i = 67; i >= 0; i--) begin
      tmp = b;
      b = a ^ refF(b) ^ k[i];
      a = tmp;
    end
    return {a, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one operation from a negedge; returns at the negedge where done_o is seen,
  // so a following call issues its start on the cycle right after done_o
  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key,
                               input logic [127:0] expPt, input bit holdTest,
                               input bit busyStarts, input string name);
    bit seen;
    ct_i    = ct;
    k0_i    = key;
    start_i = 1'b1;
    sbQueue.push_back(expPt);
    @(posedge clk);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (k == 0) begin
        checkOutput({name, " busy after start"}, 128'(busy_o), 128'd1);
        checkOutput({name, " done low at start"}, 128'(done_o), 128'd0);
        if (holdTest) begin
          ct_i = '1;
          k0_i = '1;
        end
      end
      if (busyStarts && (k == 9 || k == 69)) begin
        ct_i    = '1;
        start_i = 1'b1;
      end
      if (k == 120) checkOutput({name, " pt held"}, pt_o, lastPt);
      if (done_o) begin
        checkOutput({name, " latency"}, 128'(k), 128'd135);
        checkOutput({name, " busy at done"}, 128'(busy_o), 128'd0);
        if (sbQueue.size() == 0) checkOutput({name, " unexpected done"}, 128'd1, 128'd0);
        else                     checkOutput({name, " pt"}, pt_o, sbQueue.pop_front());
        lastPt = pt_o;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({name, " done timeout"}, 128'd0, 128'd1);
  endtask

  task automatic resetMidOperation();
    int doneCount;
    ct_i    = STD_CT;
    k0_i    = STD_KEY;
    start_i = 1'b1;
    sbQueue.push_back(STD_PT);
    @(posedge clk);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset mid-op busy", 128'(busy_o), 128'd0);
    checkOutput("reset mid-op done", 128'(done_o), 128'd0);
    checkOutput("reset mid-op pt", pt_o, 128'd0);
    sbQueue.delete();
    lastPt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done_o) doneCount++;
    end
    checkOutput("no done after reset", 128'(doneCount), 128'd0);
  endtask

  initial begin
    logic [127:0] rtPt, rtCt, rndKey, rndPt;
    compared   = 0;
    mismatched = 0;
    lastPt     = '0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    ct_i       = '0;
    k0_i       = '0;
    #12;
    checkOutput("reset busy", 128'(busy_o), 128'd0);
    checkOutput("reset done", 128'(done_o), 128'd0);
    checkOutput("reset pt", pt_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(STD_CT, STD_KEY, STD_PT, 1'b0, 1'b1, "std busy-starts");
    applyStimulus(STD_CT, STD_KEY, STD_PT, 1'b0, 1'b0, "std back-to-back");
    applyStimulus(STD_CT, STD_KEY, STD_PT, 1'b1, 1'b0, "std input-hold");

    rtPt = 128'h0123456789abcdef0123456789abcdef;
    rtCt = refEncrypt(rtPt, STD_KEY);
    applyStimulus(rtCt, STD_KEY, rtPt, 1'b0, 1'b0, "round-trip");

    applyStimulus('0, '0, refDecrypt('0, '0), 1'b0, 1'b0, "all-zero");

    start_i = 1'b0;
    repeat (3) @(negedge clk);
    resetMidOperation();
    applyStimulus(STD_CT, STD_KEY, STD_PT, 1'b0, 1'b0, "std after reset");

    for (int n = 0; n < 2; n++) begin
      rndKey = {$urandom, $urandom, $urandom, $urandom};
      rndPt  = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(refEncrypt(rndPt, rndKey), rndKey, rndPt, 1'b0, 1'b0, "random");
    end

    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("single done pulse", 128'(done_o), 128'd0);
    end
    checkOutput("pt stable when idle", pt_o, lastPt);
    checkOutput("scoreboard drained", 128'(sbQueue.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
